// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: bus widths, opcode map, fetch-state encoding and the
// instruction-length rule used by both the fetch unit and the controller.
package cpu_defs_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADA = 3'b010;
    localparam logic [2:0] OP_ANA = 3'b011;
    localparam logic [2:0] OP_REG = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    typedef enum logic [2:0] {
        REQ0  = 3'd0,
        CAP0  = 3'd1,
        REQ1  = 3'd2,
        CAP1  = 3'd3,
        VALID = 3'd4
    } fetch_state_t;

    // Memory-reference ops (top bit clear) and jumps carry a 13-bit operand byte pair.
    function automatic logic is_two_byte(input logic [DATA_W-1:0] byte0);
        return (byte0[DATA_W-1] == 1'b0) || (byte0[DATA_W-1 -: 3] == OP_JMP);
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational opcode-byte to instruction-length decode; shared with the
// controller so both sides agree on which instructions carry a second byte.
module instr_len_decode
    import cpu_defs_pkg::*;
(
    input  logic [DATA_W-1:0] byte0_i,
    output logic              len2_o
);

    assign len2_o = is_two_byte(byte0_i);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads one or two bytes from byte-wide memory and
// presents a packed instruction to the controller over valid/ready.
//
// Handshake: instr_valid is high exactly while the FSM sits in VALID and the
// outputs are frozen there; a cycle with instr_valid && instr_ready transfers
// the instruction. instr_ready is ignored outside VALID. pc_load overrides all
// of this and counts as consuming whatever is being presented.
module instr_fetch_unit #(
    parameter int                ADDR_W   = cpu_defs_pkg::ADDR_W,
    parameter int                DATA_W   = cpu_defs_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic                     mem_read,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [2*DATA_W-1:0]      instr_word,
    output logic                     instr_len2,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     pc_load,
    input  logic [ADDR_W-1:0]        pc_load_addr,
    output cpu_defs_pkg::fetch_state_t dbg_state_o
);

    import cpu_defs_pkg::*;

    fetch_state_t          state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [2*DATA_W-1:0]   word_q, word_d;
    logic                  len2_q, len2_d;
    logic [ADDR_W-1:0]     ipc_q, ipc_d;
    logic                  rdata_len2;

    instr_len_decode u_len_decode (
        .byte0_i (mem_rdata),
        .len2_o  (rdata_len2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ0;
            pc_q    <= RESET_PC;
            word_q  <= '0;
            len2_q  <= 1'b0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
            len2_q  <= len2_d;
            ipc_q   <= ipc_d;
        end
    end

    // The read strobe is combinational from REQ states so that memory data is
    // ready to capture in the immediately following CAP cycle.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        word_d   = word_q;
        len2_d   = len2_q;
        ipc_d    = ipc_q;
        mem_read = 1'b0;
        mem_addr = '0;

        if (pc_load) begin
            state_d = REQ0;
            pc_d    = pc_load_addr;
        end else begin
            case (state_q)
                REQ0: begin
                    if (fetch_en) begin
                        mem_read = 1'b1;
                        mem_addr = pc_q;
                        ipc_d    = pc_q;
                        state_d  = CAP0;
                    end
                end
                CAP0: begin
                    word_d  = {mem_rdata, {DATA_W{1'b0}}};
                    len2_d  = rdata_len2;
                    pc_d    = pc_q + 1'b1;
                    state_d = rdata_len2 ? REQ1 : VALID;
                end
                REQ1: begin
                    if (fetch_en) begin
                        mem_read = 1'b1;
                        mem_addr = pc_q;
                        state_d  = CAP1;
                    end
                end
                CAP1: begin
                    word_d[DATA_W-1:0] = mem_rdata;
                    pc_d               = pc_q + 1'b1;
                    state_d            = VALID;
                end
                VALID: begin
                    if (instr_ready) begin
                        state_d = REQ0;
                    end
                end
                default: state_d = REQ0;
            endcase
        end

        // Keep the bus quiet while reset is held even though the state is REQ0.
        if (rst) begin
            mem_read = 1'b0;
            mem_addr = '0;
        end
    end

    assign instr_valid = (state_q == VALID);
    assign instr_word  = word_q;
    assign instr_len2  = len2_q;
    assign instr_pc    = ipc_q;
    assign dbg_state_o = state_q;

endmodule
